// File: rtl/vec_compare_seq.sv
// vec_compare_seq
//   Drives the shared W-bit compare unit (A-B, zero flag) one lane per cycle
//   over a packed operand pair, then returns one result record.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_valid/start_ready    operand pair offered / accepted (ready only in IDLE)
//   vec_a, vec_b, early_exit   operands (lane i = [i*W +: W]) and early-stop flag,
//                              all captured on the accepting edge
//   cmp_a, cmp_b -> cmp_c, cmp_zero
//                              lane operands out to the compare unit, difference
//                              and zero flag back (purely combinational unit)
//   done_valid/done_ready      result offered / taken by writeback
//   eq_mask, all_eq, diff_found, first_diff_idx, diff_value
//                              result record, constant while done_valid=1
//   dbg_state_o                current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once done_valid rises it stays high, with every result field
// unchanged, until the edge on which done_ready is seen high.

module vec_compare_seq #(
  parameter int LANES = 8,
  parameter int W     = 4,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [LANES*W-1:0]   vec_a,
  input  logic [LANES*W-1:0]   vec_b,
  input  logic                 early_exit,
  output logic [W-1:0]         cmp_a,
  output logic [W-1:0]         cmp_b,
  input  logic [W-1:0]         cmp_c,
  input  logic                 cmp_zero,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [LANES-1:0]     eq_mask,
  output logic                 all_eq,
  output logic                 diff_found,
  output logic [IDX_W-1:0]     first_diff_idx,
  output logic [W-1:0]         diff_value,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [LANES*W-1:0]   a_q;
  logic [LANES*W-1:0]   b_q;
  logic                 early_q;
  logic [LANES-1:0]     eq_mask_q;
  logic                 diff_found_q;
  logic [IDX_W-1:0]     first_idx_q;
  logic [W-1:0]         diff_val_q;

  logic                 last_lane;

  assign last_lane = (idx_q == IDX_W'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      early_q      <= 1'b0;
      eq_mask_q    <= '0;
      diff_found_q <= 1'b0;
      first_idx_q  <= '0;
      diff_val_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            a_q          <= vec_a;
            b_q          <= vec_b;
            early_q      <= early_exit;
            idx_q        <= '0;
            eq_mask_q    <= '0;
            diff_found_q <= 1'b0;
            first_idx_q  <= '0;
            diff_val_q   <= '0;
            state_q      <= S_RUN;
          end
        end
        S_RUN: begin
          eq_mask_q[idx_q] <= cmp_zero;
          // Only the lowest mismatching lane is recorded; later ones are ignored.
          if (!cmp_zero && !diff_found_q) begin
            diff_found_q <= 1'b1;
            first_idx_q  <= idx_q;
            diff_val_q   <= cmp_c;
          end
          if (last_lane || (early_q && !cmp_zero)) begin
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (done_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Lane operands come straight from the latched vectors so the compare unit
  // result is sampled in the same cycle the lane is presented.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    if (state_q == S_RUN) begin
      cmp_a = a_q[int'(idx_q) * W +: W];
      cmp_b = b_q[int'(idx_q) * W +: W];
    end
  end

  assign start_ready    = (state_q == S_IDLE);
  assign done_valid     = (state_q == S_DONE);
  assign eq_mask        = eq_mask_q;
  assign diff_found     = diff_found_q;
  assign first_diff_idx = first_idx_q;
  assign diff_value     = diff_val_q;
  // all_eq is only meaningful alongside done_valid.
  assign all_eq         = (state_q == S_DONE) && !diff_found_q;
  assign dbg_state_o    = state_q;

endmodule
